// File: rtl/hazard_if.sv
// hazard_if: decode/execute status into the interlock controller and pipeline
// controls back out.
//   master : drives id_* decode fields and ex_redirect, reads the controls
//   slave  : hazard_ctrl side, reads decode/execute status and drives
//            pc_en, if_id_en, if_id_flush, id_ex_bubble, busy
// Optional macro HAZARD_PERF_EN adds 32-bit stall_cnt / flush_cnt outputs.
interface hazard_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_load;
    logic       ex_redirect;

    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       busy;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_load, ex_redirect,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble, busy,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_load, ex_redirect,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble, busy,
               stall_cnt, flush_cnt
    );
`else
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_load, ex_redirect,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble, busy
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_load, ex_redirect,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble, busy
    );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock controller for the fetch/decode/execute path.
// Stalls decode on load-use hazards against a single-entry load scoreboard and
// holds IF/ID flush for FLUSH_CYCLES cycles after a taken redirect.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low (forces HOLD, clears scoreboard/counter)
//   bus  : hazard_if.slave (decode fields + ex_redirect in; pc_en, if_id_en,
//          if_id_flush, id_ex_bubble, busy out; all outputs combinational
//          from state and inputs)
// Parameters: FLUSH_CYCLES (1..7), LOAD_LAT (1..3).
// Optional macro HAZARD_PERF_EN adds saturating stall_cnt / flush_cnt counters.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned LOAD_LAT     = 1
) (
    input  logic    clk,
    input  logic    rst,
    hazard_if.slave bus
);
    localparam int unsigned REG_W   = 5;
    localparam int unsigned LDCNT_W = 2;
    localparam int unsigned FCNT_W  = 3;

    localparam logic [LDCNT_W-1:0] LD_RELOAD   = LDCNT_W'(LOAD_LAT);
    localparam logic [FCNT_W-1:0]  FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam bit                 MULTI_FLUSH = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [REG_W-1:0]    r_ld_rd;
    logic [REG_W-1:0]    w_ld_rd_nxt;
    logic [LDCNT_W-1:0]  r_ld_cnt;
    logic [LDCNT_W-1:0]  w_ld_cnt_nxt;
    logic [FCNT_W-1:0]   r_fcnt;
    logic [FCNT_W-1:0]   w_fcnt_nxt;

    logic w_src_match;
    logic w_hazard;
    logic w_flush_now;
    logic w_issue;
    logic w_ld_track;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_if_id_flush;
    logic w_id_ex_bubble;
    logic w_busy;

    // A used decode source matches the destination of a load still in flight
    assign w_src_match = (bus.id_rs1_used && (bus.id_rs1 == r_ld_rd)) ||
                         (bus.id_rs2_used && (bus.id_rs2 == r_ld_rd));
    assign w_hazard    = bus.id_valid && (r_ld_cnt != '0) && w_src_match;
    assign w_flush_now = (r_state != ST_RUN) || bus.ex_redirect;
    assign w_issue     = bus.id_valid && !w_hazard && !w_flush_now;
    // x0 is never tracked, so it can never produce a hazard
    assign w_ld_track  = w_issue && bus.id_load && bus.id_reg_write && (bus.id_rd != '0);

    // Scoreboard: a newly issued load overrides the countdown
    always_comb begin : scoreboard_nxt
        w_ld_rd_nxt  = r_ld_rd;
        w_ld_cnt_nxt = r_ld_cnt;
        if (w_ld_track) begin
            w_ld_rd_nxt  = bus.id_rd;
            w_ld_cnt_nxt = LD_RELOAD;
        end else if (r_ld_cnt != '0) begin
            w_ld_cnt_nxt = r_ld_cnt - LDCNT_W'(1);
        end
    end

    // Next state and pipeline controls; defaults are the HOLD values
    always_comb begin : fsm_nxt
        w_state_nxt    = r_state;
        w_fcnt_nxt     = r_fcnt;
        w_pc_en        = 1'b0;
        w_if_id_en     = 1'b0;
        w_if_id_flush  = 1'b1;
        w_id_ex_bubble = 1'b1;
        case (r_state)
            ST_HOLD: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.ex_redirect) begin
                    w_pc_en    = 1'b1;
                    w_if_id_en = 1'b1;
                    if (MULTI_FLUSH) begin
                        w_state_nxt = ST_FLUSH;
                        w_fcnt_nxt  = FCNT_RELOAD;
                    end
                end else if (w_hazard) begin
                    w_if_id_flush = 1'b0;
                end else begin
                    w_pc_en        = 1'b1;
                    w_if_id_en     = 1'b1;
                    w_if_id_flush  = 1'b0;
                    w_id_ex_bubble = 1'b0;
                end
            end
            ST_FLUSH: begin
                w_pc_en    = 1'b1;
                w_if_id_en = 1'b1;
                // A redirect during the flush restarts the window
                if (bus.ex_redirect) begin
                    w_fcnt_nxt = FCNT_RELOAD;
                end else begin
                    w_fcnt_nxt = r_fcnt - FCNT_W'(1);
                    if (r_fcnt == FCNT_W'(1)) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
            end
        endcase
    end

    assign w_busy = (r_state != ST_RUN);

    // State, scoreboard and flush counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_HOLD;
            r_ld_rd  <= '0;
            r_ld_cnt <= '0;
            r_fcnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ld_rd  <= w_ld_rd_nxt;
            r_ld_cnt <= w_ld_cnt_nxt;
            r_fcnt   <= w_fcnt_nxt;
        end
    end

    assign bus.pc_en        = w_pc_en;
    assign bus.if_id_en     = w_if_id_en;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_bubble = w_id_ex_bubble;
    assign bus.busy         = w_busy;

`ifdef HAZARD_PERF_EN
    localparam int unsigned PERF_W = 32;

    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;
    logic              w_stall_evt;
    logic              w_flush_evt;

    assign w_stall_evt = (r_state == ST_RUN) && !bus.ex_redirect && w_hazard;
    assign w_flush_evt = w_if_id_flush && (r_state != ST_HOLD);

    // Saturating event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + PERF_W'(1);
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    // Performance counters not built
`endif
endmodule
